uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Configurable bit time, data width, parity and stop-bit count.
- Adds a 2-flop input synchroniser, false-start rejection, parity and overrun checking, and a first-word-fall-through receive FIFO.
- Sits between the board RxD pin and the CPU/register-file read path.

Parameters:
- CLKS_PER_BIT, 2600, clk cycles per bit (2600 = 12'hA28 at the current board clock); must be >= 4.
- DATA_BITS, 8, data bits per frame, 5..9, LSB first.
- PARITY_EN, 0, 1 = parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.
- STOP_BITS, 1, stop bits checked per frame, 1 or 2.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- clr  in  1  synchronous active-high reset.
- RxD  in  1  asynchronous serial input, idle high.
- rd_en  in  1  pop FIFO head this cycle.
- err_clr  in  1  clear FE/PE/OE.
- rx_data  out  DATA_BITS  FIFO head word; valid while rx_valid = 1.
- rx_valid  out  1  FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held.
- FE  out  1  sticky framing error.
- PE  out  1  sticky parity error.
- OE  out  1  sticky overrun.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. With clr = 1 at a rising clk edge:
  - state = IDLE; baud counter, bit counter and FIFO pointers = 0.
  - rx_valid = 0, fifo_count = 0, FE = PE = OE = 0, rx_data = 0.
  - Synchroniser flops = 1.
  - clr mid-frame abandons the frame; nothing is pushed.
- Synchroniser: rx_s = RxD delayed by 2 flops. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2 (integer division). The baud counter increments every cycle in START/DATA/PARITY/STOP. A "tick" is the cycle in which the counter equals its terminal value; the counter then returns to 0.
- States:
  - IDLE: counters = 0. rx_s = 0 -> START.
  - START: terminal value HALF-1. At the tick, rx_s = 0 -> DATA; rx_s = 1 -> IDLE (glitch rejected, nothing pushed, no flag set).
  - DATA: terminal value CLKS_PER_BIT-1. At each tick, shift rx_s into shift reg bit [DATA_BITS-1] (right shift, LSB first). After DATA_BITS ticks -> PARITY if PARITY_EN, else STOP.
  - PARITY: one tick. Expected bit = XOR(data) ^ PARITY_ODD. A mismatch marks the frame parity-bad.
  - STOP: one tick per stop bit. Any stop sample = 0 marks the frame framing-bad. After the last stop tick:
    - push the frame;
    - good framing -> IDLE;
    - framing-bad -> WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s = 1, then -> IDLE. Prevents a break from re-triggering continuously.
- Error flags:
  - The frame is pushed even when parity-bad or framing-bad.
  - FE/PE set in the push cycle.
  - Set has priority over err_clr in the same cycle.
- FIFO:
  - First-word-fall-through: rx_data is the combinational head.
  - Push becomes visible (rx_valid / fifo_count) on the edge after the final stop tick.
  - rd_en with an empty FIFO is ignored.
  - Push and pop in the same cycle: both occur, count unchanged, including when full (no overrun).
  - Push when full without pop: the frame is dropped, OE set, FIFO contents untouched.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a frame whose start edge arrives at RxD at cycle 0 is readable at about 2 + HALF + (DATA_BITS + PARITY_EN + STOP_BITS)*CLKS_PER_BIT + 1 cycles.

Test Plan (CLKS_PER_BIT = 16 unless stated):
- 8N1, send 0xA5 with stop = 1 -> rx_valid rises once, rx_data = 0xA5, fifo_count = 1, FE = PE = OE = 0; rd_en pulse -> rx_valid = 0.
- 5-cycle low glitch on idle RxD -> state returns to IDLE, no push, all flags 0; a following 0x3C is received correctly.
- PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 0 (wrong) -> 0x07 pushed, PE = 1; err_clr -> PE = 0.
- Send 0x55 with stop = 0, RxD held low 3 bit times -> 0x55 pushed, FE = 1, no further frames until RxD high, then 0x81 received normally.
- FIFO_DEPTH = 4, send 5 frames 0x01..0x05 with no reads -> fifo_count = 4, OE = 1, reads yield 0x01..0x04. Repeat with rd_en asserted in frame 5's push cycle -> no OE, 0x05 retained.
- Assert clr during data bit 4 of a frame -> all outputs at reset values next cycle; the next full frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, false-start rejection,
// parity/framing/overrun detection and a first-word-fall-through receive FIFO.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 2600,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                clr,
  input  logic                                RxD,
  input  logic                                rd_en,
  input  logic                                err_clr,
  output logic [DATA_BITS-1:0]                rx_data,
  output logic                                rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                FE,
  output logic                                PE,
  output logic                                OE
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_sync2;
  logic [BW-1:0]          r_baud;
  logic [3:0]             r_bitcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_pbad;
  logic                   r_fbad;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_fe;
  logic                   r_pe;
  logic                   r_oe;

  logic w_rx_s;
  logic w_counting;
  logic w_tick;
  logic w_last_bit;
  logic w_last_stop;
  logic w_fbad_now;
  logic w_par_exp;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_ovf;

  assign w_rx_s      = r_sync2;
  assign w_counting  = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_tick      = ((r_state == S_START) && (r_baud == HALF_LAST)) ||
                       (w_counting && (r_state != S_START) && (r_baud == BIT_LAST));
  assign w_last_bit  = (r_bitcnt == 4'(DATA_BITS - 1));
  assign w_last_stop = (r_bitcnt == 4'(STOP_BITS - 1));
  assign w_fbad_now  = r_fbad | ~w_rx_s;
  assign w_par_exp   = (^r_shift) ^ PARITY_ODD[0];
  assign w_push      = (r_state == S_STOP) && w_tick && w_last_stop;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a framing-bad frame parks in S_WAIT so a held break cannot retrigger.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_rx_s) w_state_nxt = S_START; else w_state_nxt = S_IDLE;
      S_START:  if (w_tick) w_state_nxt = w_rx_s ? S_IDLE : S_DATA; else w_state_nxt = S_START;
      S_DATA:   if (w_tick && w_last_bit) w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                else w_state_nxt = S_DATA;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP; else w_state_nxt = S_PARITY;
      S_STOP:   if (w_push) w_state_nxt = w_fbad_now ? S_WAIT : S_IDLE; else w_state_nxt = S_STOP;
      S_WAIT:   if (w_rx_s) w_state_nxt = S_IDLE; else w_state_nxt = S_WAIT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Baud/bit counters, data shifter and per-frame error capture.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_baud   <= '0;
      r_bitcnt <= 4'd0;
      r_shift  <= '0;
      r_pbad   <= 1'b0;
      r_fbad   <= 1'b0;
    end else begin
      r_baud   <= (w_counting && !w_tick) ? r_baud + BW'(1) : '0;
      r_bitcnt <= (w_state_nxt != r_state) ? 4'd0 : (w_tick ? r_bitcnt + 4'd1 : r_bitcnt);
      if (r_state == S_DATA && w_tick) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      if (r_state == S_IDLE) begin
        r_pbad <= 1'b0;
        r_fbad <= 1'b0;
      end else if (r_state == S_PARITY && w_tick) begin
        r_pbad <= w_rx_s ^ w_par_exp;
      end else if (r_state == S_STOP && w_tick) begin
        r_fbad <= w_fbad_now;
      end
    end
  end

  assign w_pop  = rd_en && (r_count != '0);
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovf  = w_push && w_full && !w_pop;

  // FIFO storage; contents need no reset since rx_data is masked while empty.
  always_ff @(posedge clk) begin
    if (!clr && w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_wr) r_count <= r_count - CW'(1);
      else                     r_count <= r_count;
    end
  end

  // Sticky error flags; a set in the same cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_fe <= 1'b0;
      r_pe <= 1'b0;
      r_oe <= 1'b0;
    end else begin
      r_fe <= (w_push && w_fbad_now) ? 1'b1 : (err_clr ? 1'b0 : r_fe);
      r_pe <= (w_push && r_pbad)     ? 1'b1 : (err_clr ? 1'b0 : r_pe);
      r_oe <= w_ovf                  ? 1'b1 : (err_clr ? 1'b0 : r_oe);
    end
  end

  assign rx_valid   = (r_count != '0);
  assign rx_data    = rx_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count = r_count;
  assign FE         = r_fe;
  assign PE         = r_pe;
  assign OE         = r_oe;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance (a) and an 8E1 instance (b) driven by
// directed and random frames, checked against a queue-based reference model.
module tb_uart_rx_param;

  localparam int C    = 16;
  localparam int HALF = C / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, rxd_a, rxd_b, rd_a, rd_b, ec_a, ec_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic [2:0] cnt_a, cnt_b;
  logic       fe_a, pe_a, oe_a, fe_b, pe_b, oe_b;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         mfe [0:1];
  bit         mpe [0:1];
  bit         moe [0:1];

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .clr(clr), .RxD(rxd_a), .rd_en(rd_a), .err_clr(ec_a),
    .rx_data(data_a), .rx_valid(valid_a), .fifo_count(cnt_a),
    .FE(fe_a), .PE(pe_a), .OE(oe_a));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .clr(clr), .RxD(rxd_b), .rd_en(rd_b), .err_clr(ec_b),
    .rx_data(data_b), .rx_valid(valid_b), .fifo_count(cnt_b),
    .FE(fe_b), .PE(pe_b), .OE(oe_b));

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int sel, input string tag);
    int         sz;
    logic [7:0] hd;
    if (sel == 0) begin sz = qa.size(); hd = (sz > 0) ? qa[0] : 8'h00; end
    else          begin sz = qb.size(); hd = (sz > 0) ? qb[0] : 8'h00; end
    cmp({tag, ".valid"}, 32'(sel ? valid_b : valid_a), 32'(sz != 0));
    cmp({tag, ".count"}, 32'(sel ? cnt_b : cnt_a),     32'(sz));
    cmp({tag, ".data"},  32'(sel ? data_b : data_a),   32'(hd));
    cmp({tag, ".FE"},    32'(sel ? fe_b : fe_a),       32'(mfe[sel]));
    cmp({tag, ".PE"},    32'(sel ? pe_b : pe_a),       32'(mpe[sel]));
    cmp({tag, ".OE"},    32'(sel ? oe_b : oe_a),       32'(moe[sel]));
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_rxd(input int sel, input logic v);
    if (sel == 0) rxd_a = v; else rxd_b = v;
  endtask

  task automatic set_rd(input int sel, input logic v);
    if (sel == 0) rd_a = v; else rd_b = v;
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2; i++) begin mfe[i] = 0; mpe[i] = 0; moe[i] = 0; end
  endtask

  // Reference behaviour of one received frame: flags, then FIFO push/pop/overrun.
  task automatic model_push(input int sel, input logic [7:0] d, input bit pbad,
                            input bit fbad, input bit pop);
    if (fbad) mfe[sel] = 1;
    if (pbad) mpe[sel] = 1;
    if (sel == 0) begin
      if (pop && qa.size() > 0) void'(qa.pop_front());
      if (qa.size() < 4) qa.push_back(d); else moe[sel] = 1;
    end else begin
      if (pop && qb.size() > 0) void'(qb.pop_front());
      if (qb.size() < 4) qb.push_back(d); else moe[sel] = 1;
    end
  endtask

  // Serialise a frame; optionally hold rd_en in exactly the push cycle.
  task automatic send(input int sel, input logic [7:0] d, input logic par,
                      input logic stp, input bit pop_push);
    logic bits [0:11];
    int   n, e, push_e;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (sel != 0) begin bits[n] = par; n++; end
    bits[n] = stp; n++;
    push_e = 3 + HALF + (n - 1) * C;
    e = 0;
    for (int i = 0; i < n; i++) begin
      set_rxd(sel, bits[i]);
      for (int c = 0; c < C; c++) begin
        @(posedge clk); e++; #1;
        if (pop_push) set_rd(sel, (e == push_e - 1));
      end
    end
    model_push(sel, d, (sel != 0) && (par != ^d), !stp, pop_push);
  endtask

  task automatic do_read(input int sel);
    set_rd(sel, 1'b1);
    tick(1);
    set_rd(sel, 1'b0);
    if (sel == 0) begin if (qa.size() > 0) void'(qa.pop_front()); end
    else          begin if (qb.size() > 0) void'(qb.pop_front()); end
  endtask

  task automatic err_clear(input int sel);
    if (sel == 0) ec_a = 1'b1; else ec_b = 1'b1;
    tick(1);
    ec_a = 1'b0; ec_b = 1'b0;
    mfe[sel] = 0; mpe[sel] = 0; moe[sel] = 0;
  endtask

  task automatic idle(input int sel, input int n);
    set_rxd(sel, 1'b1);
    tick(n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit         bp, bs, pp;
    clr = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1;
    rd_a = 1'b0; rd_b = 1'b0; ec_a = 1'b0; ec_b = 1'b0;
    model_reset();
    tick(2);
    clr = 1'b0;
    check_all(0, "reset_a");
    check_all(1, "reset_b");
    idle(0, 4);

    // 8N1 basic frame and pop
    send(0, 8'hA5, 1'b0, 1'b1, 0);
    idle(0, C);
    check_all(0, "a5_rx");
    do_read(0);
    check_all(0, "a5_pop");

    // Short low glitch is rejected, then a clean frame
    set_rxd(0, 1'b0); tick(5);
    idle(0, 3 * C);
    check_all(0, "glitch");
    send(0, 8'h3C, 1'b0, 1'b1, 0);
    idle(0, C);
    check_all(0, "3c_rx");
    do_read(0);

    // Even parity with wrong parity bit
    send(1, 8'h07, 1'b0, 1'b1, 0);
    idle(1, C);
    check_all(1, "par_bad");
    err_clear(1);
    check_all(1, "par_clr");
    do_read(1);

    // Framing error followed by a held break
    send(0, 8'h55, 1'b0, 1'b0, 0);
    tick(2 * C);
    check_all(0, "break_low");
    idle(0, C);
    check_all(0, "break_high");
    send(0, 8'h81, 1'b0, 1'b1, 0);
    idle(0, C);
    check_all(0, "after_break");
    do_read(0);
    check_all(0, "pop_55");
    do_read(0);
    err_clear(0);
    check_all(0, "fe_clr");

    // Overrun: five frames, no reads
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send(0, d, 1'b0, 1'b1, 0);
      idle(0, C);
    end
    check_all(0, "ovr_full");
    for (int i = 0; i < 4; i++) begin do_read(0); check_all(0, "ovr_drain"); end
    err_clear(0);

    // Full FIFO with pop in the push cycle: no overrun
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send(0, d, 1'b0, 1'b1, (i == 5));
      idle(0, C);
    end
    check_all(0, "pushpop_full");
    for (int i = 0; i < 4; i++) begin do_read(0); check_all(0, "pushpop_drain"); end

    // Reset in the middle of data bit 4
    send(0, 8'h11, 1'b0, 1'b0, 0);
    idle(0, C);
    check_all(0, "pre_clr");
    d = 8'hC3;
    set_rxd(0, 1'b0); tick(C);
    for (int i = 0; i < 4; i++) begin set_rxd(0, d[i]); tick(C); end
    set_rxd(0, d[4]); tick(5);
    clr = 1'b1; tick(1); clr = 1'b0;
    set_rxd(0, 1'b1);
    model_reset();
    check_all(0, "clr_mid_a");
    check_all(1, "clr_mid_b");
    idle(0, 2 * C);
    check_all(0, "clr_idle");
    send(0, 8'hC3, 1'b0, 1'b1, 0);
    idle(0, C);
    check_all(0, "c3_rx");
    do_read(0);

    // Random frames on the parity instance
    for (int k = 0; k < 14; k++) begin
      d  = 8'($urandom);
      bp = ($urandom_range(3) == 0);
      bs = ($urandom_range(3) == 0);
      pp = ($urandom_range(3) == 0);
      send(1, d, (^d) ^ bp, !bs, pp);
      idle(1, C);
      check_all(1, "rnd_frame");
      repeat ($urandom_range(2)) do_read(1);
      if ($urandom_range(4) == 0) err_clear(1);
      check_all(1, "rnd_after");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
